mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 3, max consecutive data grants while a fetch request is pending before fetch is forced to win (1..15).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 i_req  in  1  instruction-fetch request; held with i_addr stable until accepted.
REQ-005 i_addr  in  32  fetch byte address.
REQ-006 i_ready  out  1  fetch request accepted this cycle.
REQ-007 i_rvalid  out  1  fetch response pulse; i_rdata valid.
REQ-008 i_rdata  out  32  fetch read data.
REQ-009 d_req  in  1  data request; d_we, d_addr, d_wdata and d_wmask held stable until accepted.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  store data, lane-aligned.
REQ-013 d_wmask  in  4  store byte enables.
REQ-014 d_ready  out  1  data request accepted this cycle.
REQ-015 d_rvalid  out  1  data response pulse (load data or store ack).
REQ-016 d_rdata  out  32  load data; 0 for store ack.
REQ-017 mem_addr  out  32  shared memory address.
REQ-018 mem_r_enable  out  1  memory read strobe.
REQ-019 mem_w_enable  out  1  memory write strobe.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_wmask  out  4  memory byte enables.
REQ-022 mem_rdata  in  32  memory read data, valid exactly 1 cycle after mem_r_enable.

Function
REQ-023 FSM states SHALL be IDLE and RESP; one transaction outstanding maximum; throughput is one accept per 2 cycles.
REQ-024 Acceptance SHALL occur only in IDLE; in RESP i_ready = d_ready = 0 regardless of requests.
REQ-025 In IDLE: if exactly one requester asserts req, that requester SHALL be granted in the same cycle (ready combinational from req).
REQ-026 In IDLE with both requesting: data wins unless starve_cnt == STARVE_LIMIT, then fetch wins.
REQ-027 starve_cnt (4-bit) SHALL increment on each data grant while i_req = 1, clear on a fetch grant or any IDLE cycle with i_req = 0, and saturate at STARVE_LIMIT.
REQ-028 On grant: mem_addr = granted address; mem_r_enable = 1 for fetch or load; mem_w_enable = 1 and mem_wdata/mem_wmask = d_wdata/d_wmask for store; otherwise these outputs SHALL be 0.
REQ-029 When no grant: mem_addr = 0, mem_r_enable = 0, mem_w_enable = 0, mem_wdata = 0, mem_wmask = 0.
REQ-030 On grant, FSM goes IDLE -> RESP and latches owner (fetch/data) and kind (read/write); RESP -> IDLE unconditionally on the next cycle.
REQ-031 In RESP: owner's rvalid = 1 for exactly that cycle; a read response SHALL carry rdata = mem_rdata; a store response SHALL carry d_rdata = 0; a fetch store is impossible.
REQ-032 i_rdata/d_rdata SHALL be 0 whenever the corresponding rvalid is 0.
REQ-033 Fetch with nonzero i_addr[1:0] SHALL be passed through unmodified; alignment and lane selection belong to the requester.
REQ-034 Requests dropped before acceptance SHALL produce no memory access and no response.

Reset
REQ-035 While reset = 1: state = IDLE, starve_cnt = 0, owner cleared, all ready, rvalid, rdata and mem_* outputs = 0.
REQ-036 Reset asserted while in RESP SHALL discard the outstanding response; no rvalid follows reset release.
REQ-037 The first grant is possible in the first cycle with reset = 0.

Verification
REQ-038 Single fetch: i_req = 1, i_addr = 0x10, mem_rdata = 0x00500093 next cycle -> i_ready in cycle 0, mem_r_enable = 1, mem_addr = 0x10; i_rvalid = 1 and i_rdata = 0x00500093 in cycle 1.
REQ-039 Store: d_req = 1, d_we = 1, d_addr = 0x104, d_wdata = 0x0000AB00, d_wmask = 4'b0010 -> mem_w_enable = 1 with identical data/mask, mem_r_enable = 0; d_rvalid = 1 and d_rdata = 0 one cycle later.
REQ-040 Contention: i_req and d_req both held high continuously (loads) with STARVE_LIMIT = 3 -> grant sequence D, D, D, I, D, D, D, I; no two consecutive accepts closer than 2 cycles.
REQ-041 RESP blocking: new d_req during a fetch RESP cycle -> d_ready = 0 that cycle, d_ready = 1 the following cycle.
REQ-042 Reset mid-transaction: load accepted, reset = 1 in the RESP cycle -> d_rvalid = 0, all outputs 0; after release an immediately held i_req is granted in the first cycle.
REQ-043 Dropped request: d_req high 1 cycle while FSM is in RESP, then low -> no mem access and no d_rvalid.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: instruction-fetch port, data port and the single memory port.
// Requests are held with their payload stable until ready; rvalid pulses once per accepted request.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
        output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
        output mem_addr, mem_r_enable, mem_w_enable, mem_wdata, mem_wmask
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
        input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
        input  mem_addr, mem_r_enable, mem_w_enable, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-state arbiter sharing one single-cycle-latency memory between fetch and data requesters.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          dbg_state,
    output logic [3:0]    dbg_starve_cnt
);
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       owner_data;
    logic       owner_write;
    logic       grant_i, grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            owner_data  <= 1'b0;
            owner_write <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (grant_i || grant_d) begin
                owner_data  <= grant_d;
                owner_write <= grant_d && bus.d_we;
            end
        end
    end

    always_comb begin
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        state_nxt  = state;
        starve_nxt = starve_cnt;
        if (state == IDLE && !reset) begin
            if (bus.d_req && (!bus.i_req || starve_cnt != LIMIT)) begin
                grant_d = 1'b1;
            end else if (bus.i_req) begin
                grant_i = 1'b1;
            end
            if (grant_i || grant_d) begin
                state_nxt = RESP;
            end
            // The count only measures how long a waiting fetch has been passed over.
            if (grant_i || !bus.i_req) begin
                starve_nxt = 4'd0;
            end else if (grant_d && starve_cnt != LIMIT) begin
                starve_nxt = starve_cnt + 4'd1;
            end
        end else if (state == RESP) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        bus.i_ready      = grant_i;
        bus.d_ready      = grant_d;
        bus.i_rvalid     = 1'b0;
        bus.i_rdata      = 32'h0;
        bus.d_rvalid     = 1'b0;
        bus.d_rdata      = 32'h0;
        bus.mem_addr     = 32'h0;
        bus.mem_r_enable = 1'b0;
        bus.mem_w_enable = 1'b0;
        bus.mem_wdata    = 32'h0;
        bus.mem_wmask    = 4'h0;
        if (grant_i) begin
            bus.mem_addr     = bus.i_addr;
            bus.mem_r_enable = 1'b1;
        end else if (grant_d) begin
            bus.mem_addr = bus.d_addr;
            if (bus.d_we) begin
                bus.mem_w_enable = 1'b1;
                bus.mem_wdata    = bus.d_wdata;
                bus.mem_wmask    = bus.d_wmask;
            end else begin
                bus.mem_r_enable = 1'b1;
            end
        end
        // A reset landing in RESP swallows the response rather than delaying it.
        if (state == RESP && !reset) begin
            if (owner_data) begin
                bus.d_rvalid = 1'b1;
                bus.d_rdata  = owner_write ? 32'h0 : bus.mem_rdata;
            end else begin
                bus.i_rvalid = 1'b1;
                bus.i_rdata  = bus.mem_rdata;
            end
        end
    end

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a cycle-level reference model predicts grants and memory strobes,
// and queues expected responses that an independent monitor pops when rvalid appears.
module tb_mem_arbiter;
    localparam int LIMIT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       dbg_state;
    logic [3:0] dbg_starve_cnt;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // stimulus for the next cycle
    logic        n_reset, n_i_req, n_d_req, n_d_we;
    logic [31:0] n_i_addr, n_d_addr, n_d_wdata;
    logic [3:0]  n_d_wmask;
    logic [31:0] mem_nxt, fix_rdata;
    logic        have_fix;

    // reference model
    logic [32:0] exp_q[$];
    bit          busy;
    int          cnt;
    bit          g_i, g_d;
    bit          rec_on;
    byte         gseq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // monitor: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.i_rvalid || bus.d_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {30'b0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_owner", {30'b0, bus.i_rvalid, bus.d_rvalid}, e[32] ? 32'd1 : 32'd2);
                chk("resp_rdata", e[32] ? bus.d_rdata : bus.i_rdata, e[31:0]);
                chk("other_rdata", e[32] ? bus.i_rdata : bus.d_rdata, 32'h0);
            end
        end else if (!reset) begin
            chk("idle_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
        end
    end

    task automatic model_step();
        logic [31:0] e_addr, e_wd;
        logic        e_r, e_w;
        logic [3:0]  e_wm;
        if (reset) begin
            chk("rst_ready",  {30'b0, bus.i_ready, bus.d_ready}, 32'd0);
            chk("rst_rvalid", {30'b0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
            chk("rst_rdata",  bus.i_rdata | bus.d_rdata, 32'h0);
            chk("rst_mem_addr", bus.mem_addr, 32'h0);
            chk("rst_mem_ctl", {26'b0, bus.mem_r_enable, bus.mem_w_enable, bus.mem_wmask}, 32'd0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
            busy = 0;
            cnt  = 0;
            g_i  = 0;
            g_d  = 0;
            exp_q.delete();
            return;
        end
        g_d = !busy && bus.d_req && (!bus.i_req || cnt != LIMIT);
        g_i = !busy && bus.i_req && !g_d;
        e_addr = 32'h0; e_r = 0; e_w = 0; e_wd = 32'h0; e_wm = 4'h0;
        if (g_i) begin
            e_addr = bus.i_addr;
            e_r    = 1;
        end else if (g_d) begin
            e_addr = bus.d_addr;
            e_r    = !bus.d_we;
            e_w    = bus.d_we;
            e_wd   = bus.d_we ? bus.d_wdata : 32'h0;
            e_wm   = bus.d_we ? bus.d_wmask : 4'h0;
        end
        chk("i_ready", bus.i_ready, g_i);
        chk("d_ready", bus.d_ready, g_d);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_ctl", {30'b0, bus.mem_r_enable, bus.mem_w_enable}, {30'b0, e_r, e_w});
        chk("mem_wdata", bus.mem_wdata, e_wd);
        chk("mem_wmask", bus.mem_wmask, e_wm);
        if (busy) begin
            busy = 0;
        end else begin
            chk("resp_missing", exp_q.size(), 32'd0);
            if (g_i || !bus.i_req) cnt = 0;
            else if (g_d) cnt = (cnt < LIMIT) ? cnt + 1 : LIMIT;
            if (g_i) exp_q.push_back({1'b0, mem_nxt});
            if (g_d) exp_q.push_back({1'b1, bus.d_we ? 32'h0 : mem_nxt});
            busy = g_i || g_d;
            if (rec_on && busy) gseq.push_back(g_i ? "I" : "D");
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        reset         = n_reset;
        bus.i_req     = n_i_req;
        bus.i_addr    = n_i_addr;
        bus.d_req     = n_d_req;
        bus.d_we      = n_d_we;
        bus.d_addr    = n_d_addr;
        bus.d_wdata   = n_d_wdata;
        bus.d_wmask   = n_d_wmask;
        bus.mem_rdata = mem_nxt;
        mem_nxt  = have_fix ? fix_rdata : $urandom;
        have_fix = 0;
        @(negedge clk);
        model_step();
    endtask

    task automatic plan_random();
        n_reset = ($urandom_range(0, 63) == 0);
        if (!n_i_req || g_i) begin
            n_i_req  = 1'($urandom_range(0, 1));
            n_i_addr = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
            n_i_req = 0;
        end
        if (!n_d_req || g_d) begin
            n_d_req   = 1'($urandom_range(0, 1));
            n_d_we    = 1'($urandom_range(0, 1));
            n_d_addr  = $urandom;
            n_d_wdata = $urandom;
            n_d_wmask = 4'($urandom_range(0, 15));
        end else if ($urandom_range(0, 15) == 0) begin
            n_d_req = 0;
        end
    endtask

    initial begin
        string exp_seq;
        reset = 1; bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.d_wmask = 0; bus.mem_rdata = 0;
        n_reset = 1; n_i_req = 0; n_i_addr = 0; n_d_req = 0; n_d_we = 0;
        n_d_addr = 0; n_d_wdata = 0; n_d_wmask = 0;
        mem_nxt = 0; fix_rdata = 0; have_fix = 0;
        busy = 0; cnt = 0; g_i = 0; g_d = 0; rec_on = 0;

        repeat (3) cycle();
        n_reset = 0;

        // single fetch
        n_i_req = 1; n_i_addr = 32'h10; have_fix = 1; fix_rdata = 32'h0050_0093;
        cycle();
        chk("fetch_mem_addr", bus.mem_addr, 32'h10);
        n_i_req = 0;
        cycle();
        chk("fetch_rdata", bus.i_rdata, 32'h0050_0093);
        cycle();

        // store
        n_d_req = 1; n_d_we = 1; n_d_addr = 32'h104; n_d_wdata = 32'h0000_AB00; n_d_wmask = 4'b0010;
        cycle();
        chk("store_wdata", bus.mem_wdata, 32'h0000_AB00);
        n_d_req = 0;
        cycle();
        chk("store_ack", bus.d_rvalid, 1'b1);
        cycle();

        // contention with both requesters held
        n_i_req = 1; n_i_addr = 32'h200; n_d_req = 1; n_d_we = 0; n_d_addr = 32'h300;
        rec_on = 1;
        gseq.delete();
        repeat (16) cycle();
        rec_on = 0;
        exp_seq = "DDDIDDDI";
        chk("contention_len", gseq.size(), 32'd8);
        for (int k = 0; k < 8 && k < gseq.size(); k++)
            chk("contention_seq", 32'(gseq[k]), 32'(exp_seq[k]));
        n_i_req = 0; n_d_req = 0;
        repeat (2) cycle();

        // data request blocked by a fetch response
        n_i_req = 1;
        cycle();
        n_i_req = 0; n_d_req = 1; n_d_we = 0; n_d_addr = 32'h44;
        cycle();
        chk("blocked_d_ready", bus.d_ready, 1'b0);
        cycle();
        chk("unblocked_d_ready", bus.d_ready, 1'b1);
        n_d_req = 0;
        cycle();

        // reset during the response cycle
        n_d_req = 1;
        cycle();
        n_d_req = 0; n_reset = 1;
        cycle();
        chk("rst_mid_rvalid", bus.d_rvalid, 1'b0);
        n_reset = 0; n_i_req = 1; n_i_addr = 32'h80;
        cycle();
        chk("post_rst_grant", bus.i_ready, 1'b1);
        n_i_req = 0;
        repeat (2) cycle();

        // request dropped while blocked
        n_i_req = 1;
        cycle();
        n_i_req = 0; n_d_req = 1; n_d_we = 1;
        cycle();
        n_d_req = 0;
        cycle();
        chk("dropped_no_access", {30'b0, bus.mem_r_enable, bus.mem_w_enable}, 32'd0);
        cycle();
        chk("dropped_no_rvalid", bus.d_rvalid, 1'b0);

        repeat (3000) begin
            plan_random();
            cycle();
        end

        n_reset = 0; n_i_req = 0; n_d_req = 0;
        repeat (3) cycle();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
